// File: rtl/random_draw_client.sv
// random_draw_client: requester-side controller for the range-limited
// random generator; redraws on out-of-range/excluded values.
module random_draw_client #(
  parameter int GEN_LATENCY = 1,
  parameter int MAX_TRIES   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] req_min,
  input  logic [31:0] req_max,
  input  logic        excl_en,
  input  logic [31:0] excl_lo,
  input  logic [31:0] excl_hi,
  output logic        gen_enable,
  output logic [31:0] gen_min,
  output logic [31:0] gen_max,
  input  logic [31:0] gen_value,
  output logic [31:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        fail,
  output logic        busy,
  output logic [15:0] reject_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CHECK,
    S_HOLD
  } state_t;

  localparam logic [3:0] LAT_M1    = 4'(GEN_LATENCY - 1);
  localparam logic [7:0] TRIES_LIM = 8'(MAX_TRIES);
  localparam bit         LAT_ONE   = (GEN_LATENCY == 1);

  state_t      state;
  logic        ex_en;
  logic [31:0] ex_lo;
  logic [31:0] ex_hi;
  logic [7:0]  tries;
  logic [3:0]  cnt;

  logic        in_range;
  logic        in_excl;
  logic        accept;
  logic [7:0]  tries_nxt;

  // Acceptance test on the sampled draw; an inverted window matches nothing.
  always_comb begin
    in_range  = (gen_value >= gen_min) && (gen_value <= gen_max);
    in_excl   = ex_en && (gen_value >= ex_lo) && (gen_value <= ex_hi);
    accept    = in_range && !in_excl;
    tries_nxt = tries + 8'd1;
  end

  // Request FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      gen_enable   <= 1'b0;
      gen_min      <= '0;
      gen_max      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      fail         <= 1'b0;
      busy         <= 1'b0;
      reject_count <= '0;
      ex_en        <= 1'b0;
      ex_lo        <= '0;
      ex_hi        <= '0;
      tries        <= '0;
      cnt          <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            gen_min <= req_min;
            gen_max <= req_max;
            ex_en   <= excl_en;
            ex_lo   <= excl_lo;
            ex_hi   <= excl_hi;
            tries   <= '0;
            busy    <= 1'b1;
            if (req_min > req_max) begin
              result       <= req_min;
              fail         <= 1'b1;
              result_valid <= 1'b1;
              state        <= S_HOLD;
            end else begin
              gen_enable <= 1'b1;
              state      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          gen_enable <= 1'b0;
          if (LAT_ONE) begin
            state <= S_CHECK;
          end else begin
            cnt   <= LAT_M1;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (accept) begin
            result       <= gen_value;
            fail         <= 1'b0;
            result_valid <= 1'b1;
            state        <= S_HOLD;
          end else begin
            if (reject_count != 16'hFFFF) begin
              reject_count <= reject_count + 16'd1;
            end
            tries <= tries_nxt;
            if (tries_nxt == TRIES_LIM) begin
              result       <= gen_min;
              fail         <= 1'b1;
              result_valid <= 1'b1;
              state        <= S_HOLD;
            end else begin
              gen_enable <= 1'b1;
              state      <= S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            fail         <= 1'b0;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_draw_client.sv
// tb_random_draw_client: directed bench with a counter-based generator
// model; one latency-1 instance and one latency-3 instance.
module tb_random_draw_client;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic [31:0] req_min = '0;
  logic [31:0] req_max = '0;
  logic        excl_en = 1'b0;
  logic [31:0] excl_lo = '0;
  logic [31:0] excl_hi = '0;
  logic        ready = 1'b0;

  logic        ge1, ge3;
  logic [31:0] gmin1, gmax1, gmin3, gmax3;
  logic [31:0] gv1, gv3;
  logic [31:0] res1, res3;
  logic        rv1, rv3, fl1, fl3, bz1, bz3;
  logic [15:0] rc1, rc3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  random_draw_client #(.GEN_LATENCY(1), .MAX_TRIES(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .req_min(req_min), .req_max(req_max),
    .excl_en(excl_en), .excl_lo(excl_lo), .excl_hi(excl_hi),
    .gen_enable(ge1), .gen_min(gmin1), .gen_max(gmax1),
    .gen_value(gv1), .result(res1), .result_valid(rv1),
    .result_ready(ready), .fail(fl1), .busy(bz1),
    .reject_count(rc1)
  );

  random_draw_client #(.GEN_LATENCY(3), .MAX_TRIES(8)) dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .req_min(req_min), .req_max(req_max),
    .excl_en(excl_en), .excl_lo(excl_lo), .excl_hi(excl_hi),
    .gen_enable(ge3), .gen_min(gmin3), .gen_max(gmax3),
    .gen_value(gv3), .result(res3), .result_valid(rv3),
    .result_ready(ready), .fail(fl3), .busy(bz3),
    .reject_count(rc3)
  );

  // Generator models: seed restarts on reset, output holds its last draw.
  logic [31:0] seed1, seed3;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      seed1 <= 0;
    end else if (ge1) begin
      gv1   <= (seed1 & (gmax1 - gmin1)) + gmin1;
      seed1 <= seed1 + 1;
    end
  end
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      seed3 <= 0;
    end else if (ge3) begin
      gv3   <= (seed3 & (gmax3 - gmin3)) + gmin3;
      seed3 <= seed3 + 1;
    end
  end

  // Enable pulse counter and back-to-back-high detector for instance 1.
  int   pulses1;
  int   consec1;
  logic ge1_q;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pulses1 <= 0;
      consec1 <= 0;
      ge1_q   <= 1'b0;
    end else begin
      ge1_q <= ge1;
      if (ge1) pulses1 <= pulses1 + 1;
      if (ge1 && ge1_q) consec1 <= consec1 + 1;
    end
  end

  initial begin
    gv1 = 32'hDEAD_0001;
    gv3 = 32'hDEAD_0003;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_rv1(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (rv1) break;
      @(negedge clk);
    end
    check(tag, {31'd0, rv1}, 32'd1);
  endtask

  task automatic wait_rv3(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (rv3) break;
      @(negedge clk);
    end
    check(tag, {31'd0, rv3}, 32'd1);
  endtask

  task automatic handshake1();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic set_req(input logic [31:0] mn, input logic [31:0] mx,
                         input logic en, input logic [31:0] lo,
                         input logic [31:0] hi);
    req_min = mn;
    req_max = mx;
    excl_en = en;
    excl_lo = lo;
    excl_hi = hi;
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_valid", {31'd0, rv1}, 32'd0);
    check("rst_busy", {31'd0, bz1}, 32'd0);
    check("rst_en", {31'd0, ge1}, 32'd0);
    check("rst_result", res1, 32'd0);
    check("rst_gmin", gmin1, 32'd0);
    check("rst_rc", {16'd0, rc1}, 32'd0);

    // Basic accept: start at cycle 0, valid at cycle 3
    set_req(10, 17, 1'b0, 0, 0);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("b_en_c1", {31'd0, ge1}, 32'd1);
    check("b_busy_c1", {31'd0, bz1}, 32'd1);
    check("b_gmin", gmin1, 32'd10);
    check("b_gmax", gmax1, 32'd17);
    @(negedge clk);
    check("b_en_c2", {31'd0, ge1}, 32'd0);
    check("b_rv_c2", {31'd0, rv1}, 32'd0);
    @(negedge clk);
    check("b_rv_c3", {31'd0, rv1}, 32'd1);
    check("b_result", res1, 32'd10);
    check("b_fail", {31'd0, fl1}, 32'd0);
    check("b_rc", {16'd0, rc1}, 32'd0);
    check("b_pulses", pulses1, 32'd1);
    handshake1();
    check("b_idle_rv", {31'd0, rv1}, 32'd0);
    check("b_idle_busy", {31'd0, bz1}, 32'd0);
    check("b_idle_res", res1, 32'd10);

    // Exclusion retry: 10,11,12 rejected, 13 accepted
    do_reset();
    set_req(10, 17, 1'b1, 10, 12);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    set_req(0, 0, 1'b0, 0, 0);
    wait_rv1("x_timeout");
    check("x_result", res1, 32'd13);
    check("x_fail", {31'd0, fl1}, 32'd0);
    check("x_pulses", pulses1, 32'd4);
    check("x_consec", consec1, 32'd0);
    check("x_rc", {16'd0, rc1}, 32'd3);
    handshake1();

    // Exhaustion: every draw excluded, fallback to gen_min
    do_reset();
    set_req(10, 17, 1'b1, 10, 17);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_rv1("e_timeout");
    check("e_fail", {31'd0, fl1}, 32'd1);
    check("e_result", res1, 32'd10);
    check("e_rc", {16'd0, rc1}, 32'd8);
    cyc(3);
    check("e_pulses", pulses1, 32'd8);
    check("e_consec", consec1, 32'd0);
    handshake1();
    check("e_fail_clr", {31'd0, fl1}, 32'd0);

    // Invalid range: immediate fail, no generator activity
    do_reset();
    set_req(20, 5, 1'b0, 0, 0);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    check("i_rv", {31'd0, rv1}, 32'd1);
    check("i_fail", {31'd0, fl1}, 32'd1);
    check("i_result", res1, 32'd20);
    check("i_pulses", pulses1, 32'd0);
    handshake1();

    // Backpressure with start pulsed during HOLD
    do_reset();
    set_req(10, 17, 1'b0, 0, 0);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_rv1("p_timeout");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        set_req(0, 3, 1'b0, 0, 0);
        start1 = 1'b1;
      end else begin
        start1 = 1'b0;
      end
      check("p_rv", {31'd0, rv1}, 32'd1);
      check("p_result", res1, 32'd10);
      @(negedge clk);
    end
    check("p_gmin", gmin1, 32'd10);
    check("p_pulses", pulses1, 32'd1);
    start1 = 1'b1;
    ready  = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    ready  = 1'b0;
    check("p_busy_after", {31'd0, bz1}, 32'd0);
    check("p_rv_after", {31'd0, rv1}, 32'd0);
    @(negedge clk);
    check("p_hs_start_ign", {31'd0, bz1}, 32'd0);
    set_req(10, 17, 1'b0, 0, 0);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_rv1("p2_timeout");
    check("p2_result", res1, 32'd11);
    check("p2_pulses", pulses1, 32'd2);
    handshake1();

    // Reset during WAIT on the latency-3 instance
    do_reset();
    set_req(10, 17, 1'b0, 0, 0);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    check("r_en_c1", {31'd0, ge3}, 32'd1);
    @(negedge clk);
    check("r_wait_busy", {31'd0, bz3}, 32'd1);
    check("r_wait_en", {31'd0, ge3}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("r_busy", {31'd0, bz3}, 32'd0);
    check("r_en", {31'd0, ge3}, 32'd0);
    check("r_gmin", gmin3, 32'd0);
    check("r_gmax", gmax3, 32'd0);
    check("r_rv", {31'd0, rv3}, 32'd0);
    check("r_result", res3, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc(5);
    check("r_stale_rv", {31'd0, rv3}, 32'd0);
    check("r_stale_busy", {31'd0, bz3}, 32'd0);
    set_req(100, 103, 1'b0, 0, 0);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    wait_rv3("r2_timeout");
    check("r2_result", res3, 32'd100);
    check("r2_fail", {31'd0, fl3}, 32'd0);
    check("r2_rc", {16'd0, rc3}, 32'd0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("r2_idle", {31'd0, bz3}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
